// File: rtl/div_pkg.sv
// Shared divider-family definitions: control state encoding and step-counter sizing.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Width of a counter that indexes WIDTH iteration steps (at least one bit).
  function automatic int step_cnt_w(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/recompose_step_cell.sv
// One shift-add step of the recomposition: o_acc = i_acc + (q_bit ? i_d << i_shamt : 0).
module recompose_step_cell
  import div_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [2*WIDTH-1:0]             i_acc,
  input  logic [2*WIDTH-1:0]             i_d,
  input  logic                           i_q_bit,
  input  logic [step_cnt_w(WIDTH)-1:0]   i_shamt,
  output logic [2*WIDTH-1:0]             o_acc
);

  logic [2*WIDTH-1:0] w_addend;

  assign w_addend = i_q_bit ? (i_d << i_shamt) : '0;
  assign o_acc    = i_acc + w_addend;

endmodule

// File: rtl/div_recompose_seq.sv
// Sequential dividend rebuild (q*d + r), one quotient bit per clock.
// Optional RECOMPOSE_CHECK_EN flags operand sets with d==0 or r>=d.
module div_recompose_seq
  import div_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               din_valid,
  output logic               din_ready,
  input  logic [WIDTH-1:0]   quotient_din,
  input  logic [WIDTH-1:0]   divisor,
  input  logic [WIDTH-1:0]   remainder_din,
  output logic               dout_valid,
  input  logic               dout_ready,
  output logic [2*WIDTH-1:0] dividend_dout,
  output logic               remainder_err
);

  localparam int CW = step_cnt_w(WIDTH);
  localparam int DW = 2 * WIDTH;

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_q;
  logic [DW-1:0]    r_d;
  logic [DW-1:0]    r_acc;
  logic [DW-1:0]    w_acc_step;
  logic [CW-1:0]    r_cnt;
  logic             w_accept;
  logic             w_last;

  assign w_accept = din_valid && (r_state == IDLE);
  assign w_last   = (r_cnt == CW'(WIDTH - 1));

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_accept)   w_state_nxt = BUSY;
      BUSY:    if (w_last)     w_state_nxt = DONE;
      DONE:    if (dout_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  recompose_step_cell #(.WIDTH(WIDTH)) u_step (
    .i_acc   (r_acc),
    .i_d     (r_d),
    .i_q_bit (r_q[r_cnt]),
    .i_shamt (r_cnt),
    .o_acc   (w_acc_step)
  );

  // Accumulator is also the output register, so it holds through DONE backpressure.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q   <= '0;
      r_d   <= '0;
      r_acc <= '0;
      r_cnt <= '0;
    end else begin
      case (r_state)
        IDLE: if (w_accept) begin
          r_q   <= quotient_din;
          r_d   <= {{WIDTH{1'b0}}, divisor};
          r_acc <= {{WIDTH{1'b0}}, remainder_din};
          r_cnt <= '0;
        end
        BUSY: begin
          r_acc <= w_acc_step;
          r_cnt <= w_last ? '0 : r_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef RECOMPOSE_CHECK_EN
  logic r_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)           r_err <= 1'b0;
    else if (w_accept) r_err <= (divisor == '0) || (remainder_din >= divisor);
  end

  assign remainder_err = r_err;
`else
  assign remainder_err = 1'b0;
`endif

  assign din_ready     = (r_state == IDLE) && !rst;
  assign dout_valid    = (r_state == DONE);
  assign dividend_dout = r_acc;

endmodule

// File: tb/tb_div_recompose_seq.sv
// Scoreboard bench for div_recompose_seq (WIDTH=4); expectations follow RECOMPOSE_CHECK_EN.
module tb_div_recompose_seq;

  localparam int W = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic           din_valid;
  logic           din_ready;
  logic [W-1:0]   quotient_din;
  logic [W-1:0]   divisor;
  logic [W-1:0]   remainder_din;
  logic           dout_valid;
  logic           dout_ready;
  logic [2*W-1:0] dividend_dout;
  logic           remainder_err;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [2*W-1:0] dividend;
    logic           err;
  } exp_t;

  exp_t sb_q[$];

  always #5 clk = ~clk;

  div_recompose_seq #(.WIDTH(W)) dut (
    .clk           (clk),
    .rst           (rst),
    .din_valid     (din_valid),
    .din_ready     (din_ready),
    .quotient_din  (quotient_din),
    .divisor       (divisor),
    .remainder_din (remainder_din),
    .dout_valid    (dout_valid),
    .dout_ready    (dout_ready),
    .dividend_dout (dividend_dout),
    .remainder_err (remainder_err)
  );

  function automatic exp_t model(input logic [W-1:0] q, input logic [W-1:0] d, input logic [W-1:0] r);
    exp_t e;
    e.dividend = (2*W)'(q) * (2*W)'(d) + (2*W)'(r);
`ifdef RECOMPOSE_CHECK_EN
    e.err = (d == 0) || (r >= d);
`else
    e.err = 1'b0;
`endif
    return e;
  endfunction

  // Output monitor: a handshake seen at negedge completes on the following posedge.
  always @(negedge clk) begin
    if (!rst && dout_valid && dout_ready) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output: dividend=%0d err=%0b with empty scoreboard", dividend_dout, remainder_err);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        if (dividend_dout !== e.dividend || remainder_err !== e.err) begin
          errors++;
          $display("FAIL result: got dividend=%0d err=%0b, expected dividend=%0d err=%0b",
                   dividend_dout, remainder_err, e.dividend, e.err);
        end
      end
    end
  end

  // Present operands and return once accepted (optionally scoreboarded).
  task automatic send(input logic [W-1:0] q, input logic [W-1:0] d, input logic [W-1:0] r,
                      input bit push, output int wait_cyc);
    bit was_ready;
    quotient_din  = q;
    divisor       = d;
    remainder_din = r;
    din_valid     = 1'b1;
    wait_cyc      = 0;
    for (int k = 0; k < 50; k++) begin
      was_ready = din_ready;
      @(posedge clk);
      #1;
      if (was_ready) begin
        if (push) sb_q.push_back(model(q, d, r));
        din_valid     = 1'b0;
        quotient_din  = W'($urandom);
        divisor       = W'($urandom);
        remainder_din = W'($urandom);
        return;
      end
      wait_cyc++;
    end
    din_valid = 1'b0;
    checks++;
    errors++;
    $display("FAIL send_timeout: operands not accepted within 50 cycles");
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (sb_q.size() != 0 && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (sb_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d results outstanding after %0d cycles", sb_q.size(), budget);
      sb_q.delete();
    end
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (din_ready !== 1'b0 || dout_valid !== 1'b0 || dividend_dout !== '0 || remainder_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: rdy=%0b vld=%0b div=%0d err=%0b, expected all 0",
               din_ready, dout_valid, dividend_dout, remainder_err);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (din_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready: din_ready=%0b, expected 1", din_ready);
    end
  endtask

  task automatic test_latency();
    int w, lat;
    dout_ready = 1'b1;
    send(4'd5, 4'd3, 4'd2, 1'b1, w);
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      if (dout_valid) break;
      @(posedge clk); #1;
      lat = k;
    end
    checks++;
    if (lat !== W) begin
      errors++;
      $display("FAIL latency: dout_valid after %0d cycles, expected %0d", lat, W);
    end
    checks++;
    if (dividend_dout !== 8'd17) begin
      errors++;
      $display("FAIL basic_dividend: got %0d, expected 17", dividend_dout);
    end
    drain(20);
  endtask

  task automatic test_values();
    int w;
    dout_ready = 1'b1;
    send(4'd15, 4'd15, 4'd14, 1'b1, w); drain(20);
    send(4'd0,  4'd9,  4'd0,  1'b1, w); drain(20);
    send(4'd3,  4'd0,  4'd1,  1'b1, w); drain(20);
    send(4'd2,  4'd4,  4'd4,  1'b1, w); drain(20);
    send(4'd1,  4'd15, 4'd15, 1'b1, w); drain(20);
  endtask

  task automatic test_backpressure();
    int w;
    logic [2*W-1:0] held;
    dout_ready = 1'b0;
    send(4'd5, 4'd3, 4'd2, 1'b1, w);
    for (int k = 0; k < 20 && !dout_valid; k++) begin
      @(posedge clk); #1;
    end
    held = dividend_dout;
    checks++;
    if (dout_valid !== 1'b1 || held !== 8'd17) begin
      errors++;
      $display("FAIL bp_enter: vld=%0b div=%0d, expected vld=1 div=17", dout_valid, held);
    end
    din_valid     = 1'b1;
    quotient_din  = 4'd9;
    divisor       = 4'd9;
    remainder_din = 4'd1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      checks++;
      if (dout_valid !== 1'b1 || dividend_dout !== 8'd17 || din_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold: cyc=%0d vld=%0b div=%0d rdy=%0b, expected 1/17/0",
                 k, dout_valid, dividend_dout, din_ready);
      end
    end
    din_valid  = 1'b0;
    dout_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (dout_valid !== 1'b0 || din_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_release: vld=%0b rdy=%0b, expected vld=0 rdy=1", dout_valid, din_ready);
    end
    drain(5);
  endtask

  task automatic test_reset_mid_busy();
    int w;
    dout_ready = 1'b1;
    send(4'd7, 4'd5, 4'd1, 1'b0, w);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    checks++;
    if (dout_valid !== 1'b0 || dividend_dout !== '0 || remainder_err !== 1'b0 || din_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_busy: vld=%0b div=%0d err=%0b rdy=%0b, expected all 0",
               dout_valid, dividend_dout, remainder_err, din_ready);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      checks++;
      if (dout_valid !== 1'b0) begin
        errors++;
        $display("FAIL aborted_output: dout_valid=%0b at cycle %0d after reset, expected 0", dout_valid, k);
      end
    end
    send(4'd1, 4'd1, 4'd0, 1'b1, w);
    drain(20);
  endtask

  task automatic test_random();
    bit done = 1'b0;
    fork
      begin
        int w;
        for (int n = 0; n < 1000; n++) begin
          repeat ($urandom_range(0, 3)) begin
            @(posedge clk); #1;
          end
          send(W'($urandom), W'($urandom), W'($urandom), 1'b1, w);
        end
        drain(200);
        done = 1'b1;
      end
      begin
        while (!done) begin
          dout_ready = ($urandom_range(0, 2) != 0);
          @(posedge clk); #1;
        end
      end
    join
    dout_ready = 1'b1;
  endtask

  initial begin
    rst           = 1'b1;
    din_valid     = 1'b0;
    dout_ready    = 1'b0;
    quotient_din  = '0;
    divisor       = '0;
    remainder_din = '0;
    test_reset();
    test_latency();
    test_values();
    test_backpressure();
    test_reset_mid_busy();
    test_random();
    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
